// File: rtl/mux_arb_pkg.sv
// Shared types and the rotate-priority pick function for the 4-way round-robin arbiter.
package mux_arb_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned IDX_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // Search order last+1, last+2, last+3, last; exclude drops the final candidate (the current owner).
   function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                     input logic [IDX_W-1:0]   last,
                                     input logic               exclude);
      pick_t            p;
      logic [IDX_W-1:0] cand;
      p = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = last + IDX_W'(k);
         if (!p.found && req[cand] && !(exclude && (k == NUM_REQ))) begin
            p.found = 1'b1;
            p.idx   = cand;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_4_pick.sv
// Combinational rotate-priority encoder used by the arbiter FSM.
module rr_pick_4
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   input  logic               exclude,
   output logic [IDX_W-1:0]   idx,
   output logic               found
);

   pick_t p;

   always_comb begin
      p = rr_pick(req, last, exclude);
   end

   assign idx   = p.idx;
   assign found = p.found;

endmodule

// File: rtl/mux_rr_arbiter_4.sv
// Round-robin arbiter driving the shared 4:1 select path and registering the owner's word.
// Optional HOLD_LIMIT_EN: forces rotation after MAX_HOLD cycles when others are waiting.
module mux_rr_arbiter_4
   import mux_arb_pkg::*;
#(
   parameter int unsigned W        = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*W-1:0] data_in,
   output logic [NUM_REQ-1:0]   gnt,
   output logic                 sel0,
   output logic                 sel1,
   output logic                 busy,
   output logic [W-1:0]         out_data,
   output logic                 out_valid
);

   if ((MAX_HOLD < 1) || (MAX_HOLD > 255)) begin : g_max_hold_range
      $error("MAX_HOLD must be in 1..255");
   end

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]   sel_q, sel_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [W-1:0]       out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;

   logic [IDX_W-1:0]   win;
   logic               found;
   logic               owner_req;
   logic [W-1:0]       owner_word;
   logic               rotate;

   rr_pick_4 u_pick (
      .req     (req),
      .last    (ptr_q),
      .exclude (state_q == GRANT),
      .idx     (win),
      .found   (found)
   );

   assign owner_req  = req[ptr_q];
   assign owner_word = data_in[int'(ptr_q)*W +: W];

`ifdef HOLD_LIMIT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       others;

   assign others = |(req & ~(NUM_REQ'(1) << ptr_q));
   assign rotate = !owner_req || ((cnt_q == HOLD_LAST) && others);
`else
   assign rotate = !owner_req;
`endif

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      sel_d       = sel_q;
      ptr_d       = ptr_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
`ifdef HOLD_LIMIT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d    = GRANT;
               gnt_d      = '0;
               gnt_d[win] = 1'b1;
               sel_d      = win;
               ptr_d      = win;
`ifdef HOLD_LIMIT_EN
               cnt_d      = '0;
`endif
            end
         end
         GRANT: begin
            out_valid_d = owner_req;
            if (owner_req) begin
               out_data_d = owner_word;
            end
            if (rotate) begin
               // Hand over directly so gnt never passes through zero between owners.
               if (found) begin
                  gnt_d      = '0;
                  gnt_d[win] = 1'b1;
                  sel_d      = win;
                  ptr_d      = win;
`ifdef HOLD_LIMIT_EN
                  cnt_d      = '0;
`endif
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end
`ifdef HOLD_LIMIT_EN
            else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         sel_q       <= '0;
         ptr_q       <= 2'd3;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
`ifdef HOLD_LIMIT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
`ifdef HOLD_LIMIT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign sel0      = sel_q[0];
   assign sel1      = sel_q[1];
   assign busy      = (state_q == GRANT);
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter_4.sv
// Directed and randomized self-checking bench for mux_rr_arbiter_4 (hold-limit checks follow HOLD_LIMIT_EN).
module tb_mux_rr_arbiter_4;

   localparam int unsigned W = 8;

   logic          clk;
   logic          rst_n;
   logic [3:0]    req;
   logic [4*W-1:0] data_in;
   logic [3:0]    gnt;
   logic          sel0, sel1, busy;
   logic [W-1:0]  out_data;
   logic          out_valid;

   int n_cmp;
   int n_err;

   mux_rr_arbiter_4 #(.W(W), .MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data_in   (data_in),
      .gnt       (gnt),
      .sel0      (sel0),
      .sel1      (sel1),
      .busy      (busy),
      .out_data  (out_data),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_grant(input string tag, input logic [3:0] eg, input logic [1:0] es);
      chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
      chk({tag, "_sel"}, 32'({sel1, sel0}), 32'(es));
      chk({tag, "_busy"}, 32'(busy), 32'(eg != 4'b0000));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   logic [3:0]     p_gnt;
   logic [3:0]     p_req;
   logic [4*W-1:0] p_data;
   logic [1:0]     p_sel;
   logic [1:0]     p_own;
   logic [1:0]     g_idx;

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      req     = 4'b0000;
      data_in = {8'h44, 8'h33, 8'h22, 8'hA5};

      // Reset state
      tick();
      chk_grant("rst", 4'b0000, 2'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'h00);
      rst_n = 1'b1;

      // Single request, first word one cycle after grant, release to idle
      req = 4'b0001;
      tick();
      chk_grant("t1_g", 4'b0001, 2'd0);
      chk("t1_v0", 32'(out_valid), 32'd0);
      tick();
      chk_grant("t1_h", 4'b0001, 2'd0);
      chk("t1_v1", 32'(out_valid), 32'd1);
      chk("t1_d1", 32'(out_data), 32'hA5);
      req = 4'b0000;
      tick();
      chk_grant("t1_rel", 4'b0000, 2'd0);
      chk("t1_v2", 32'(out_valid), 32'd0);
      chk("t1_d2", 32'(out_data), 32'hA5);

      // All requesting, each owner drops after two granted cycles
      do_reset();
      req = 4'b1111;
      tick();
      for (int unsigned k = 0; k < 5; k++) begin
         chk_grant($sformatf("t2_a%0d", k), 4'b0001 << (k % 4), 2'(k % 4));
         tick();
         chk_grant($sformatf("t2_b%0d", k), 4'b0001 << (k % 4), 2'(k % 4));
         req[k % 4] = 1'b0;
         tick();
         req[k % 4] = 1'b1;
      end
      chk_grant("t2_end", 4'b0010, 2'd1);

      // Owner 2 releases while 3 and 0 rise together: 3 is searched first
      do_reset();
      req = 4'b0100;
      tick();
      chk_grant("t3_own2", 4'b0100, 2'd2);
      req = 4'b1001;
      tick();
      chk_grant("t3_own3", 4'b1000, 2'd3);
      req = 4'b0001;
      tick();
      chk_grant("t3_own0", 4'b0001, 2'd0);

      // Hold limit behaviour with two steady requesters
      do_reset();
      req = 4'b0011;
      tick();
`ifdef HOLD_LIMIT_EN
      for (int unsigned c = 0; c < 12; c++) begin
         chk_grant($sformatf("t4_hold%0d", c), (c / 4 == 1) ? 4'b0010 : 4'b0001,
                   (c / 4 == 1) ? 2'd1 : 2'd0);
         tick();
      end
`else
      for (int unsigned c = 0; c < 12; c++) begin
         chk_grant($sformatf("t4_keep%0d", c), 4'b0001, 2'd0);
         tick();
      end
`endif
      // Lone requester never loses the grant
      do_reset();
      req = 4'b0001;
      tick();
      for (int unsigned c = 0; c < 20; c++) tick();
      chk_grant("t4_alone", 4'b0001, 2'd0);

      // Reset in the middle of a grant to requester 3
      do_reset();
      req = 4'b1000;
      tick();
      tick();
      chk_grant("t5_pre", 4'b1000, 2'd3);
      chk("t5_pre_v", 32'(out_valid), 32'd1);
      chk("t5_pre_d", 32'(out_data), 32'h44);
      rst_n = 1'b0;
      tick();
      chk_grant("t5_rst", 4'b0000, 2'd0);
      chk("t5_rst_v", 32'(out_valid), 32'd0);
      chk("t5_rst_d", 32'(out_data), 32'h00);
      rst_n = 1'b1;
      tick();
      chk_grant("t5_post", 4'b1000, 2'd3);

      // Random traffic: grant shape, sel tracking and one-cycle data path
      do_reset();
      for (int unsigned i = 0; i < 10000; i++) begin
         p_gnt  = gnt;
         p_sel  = {sel1, sel0};
         req    = 4'($urandom_range(0, 15));
         data_in = $urandom;
         p_req  = req;
         p_data = data_in;
         p_own  = 2'd0;
         for (int unsigned b = 0; b < 4; b++) if (p_gnt[b]) p_own = 2'(b);
         tick();
         chk("rnd_onehot0", 32'($onehot0(gnt)), 32'd1);
         g_idx = p_sel;
         for (int unsigned b = 0; b < 4; b++) if (gnt[b]) g_idx = 2'(b);
         chk("rnd_sel", 32'({sel1, sel0}), 32'(g_idx));
         chk("rnd_valid", 32'(out_valid), 32'((p_gnt != 4'b0000) && p_req[p_own]));
         if (out_valid) chk("rnd_data", 32'(out_data), 32'(p_data[int'(p_own)*W +: W]));
`ifndef HOLD_LIMIT_EN
         if ((p_gnt != 4'b0000) && p_req[p_own]) chk("rnd_keep", 32'(gnt), 32'(p_gnt));
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter_4.md
Name: mux_rr_arbiter_4

Overview:
Round-robin arbiter and sequencer that shares one 4:1 select path between four requesters.
- Grants one requester at a time and drives the sel1/sel0 pair that steers the downstream mux_4_1-style datapath.
- Registers the selected data word with a valid flag for the consumer.
- Sits between four producer blocks and a single shared consumer.

Parameters:
W, 8, data width of each requester word.
MAX_HOLD, 4, maximum consecutive grant cycles per owner while others wait. Only used when HOLD_LIMIT_EN is defined. Legal range 1..255.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, synchronous, active-low.
req  input  4  request per requester; level, held while requester wants the path.
data_in  input  4*W  packed words; requester k occupies bits [k*W +: W].
gnt  output  4  one-hot grant, registered.
sel0  output  1  mux select LSB, registered.
sel1  output  1  mux select MSB, registered; selected index = {sel1,sel0}.
busy  output  1  high while in GRANT state.
out_data  output  W  registered word from the granted requester.
out_valid  output  1  out_data is valid this cycle.

Behaviour:
- Reset (rst_n low at a clock edge):
  - gnt=0, sel1/sel0=00, busy=0, out_data=0, out_valid=0.
  - State = IDLE, last-granted pointer = 3 (requester 0 has top priority first), hold counter = 0.
  - Reset mid-grant drops the grant at that edge, with no drain.
- State IDLE:
  - If req!=0 at edge t, the winner is chosen in search order last+1, last+2, last+3, last (mod 4).
  - From t+1: gnt=onehot(winner), sel=winner, busy=1, state GRANT, pointer=winner, counter=0.
  - If req==0, stay in IDLE.
- State GRANT, owner o:
  - Every edge: out_data <= data_in[o], out_valid <= req[o]. First valid word appears one cycle after gnt rises.
  - If req[o] falls: re-arbitrate the same edge, searching from o+1 and excluding o.
    - Another request present: switch directly to the new owner, no idle bubble. gnt changes in one cycle and is never two-hot or zero between owners.
    - No other request: go to IDLE; gnt=0, busy=0; sel holds its last value.
  - Otherwise keep the grant; the counter increments, saturating at 255.
- out_valid is low in IDLE. out_data holds its last value when not valid.
- Simultaneous requests: round-robin order decides. A requester that drops and reasserts while ungranted waits its turn.
- A req bit rising in the same cycle as a release is eligible in that arbitration.
- sel and gnt always agree: sel = index of the set gnt bit, or the last index when gnt=0.

Optional Feature:
HOLD_LIMIT_EN
- Defined: in GRANT, if counter == MAX_HOLD-1 and any other req bit is high, force a rotation at that edge as if req[o] had fallen. The pre-empted owner keeps req high and is granted again by round-robin later. If no other requester is waiting, the owner keeps the grant indefinitely.
- Not defined: the owner holds the grant until it drops req; the counter logic is not built.

Decomposition:
Shared package mux_arb_pkg holds:
- State encodings IDLE=1'b0, GRANT=1'b1.
- NUM_REQ=4 and IDX_W=2.
- A function rr_pick(req, last, exclude) returning the winning index and a found flag.

One sub-module: rr_pick_4, a combinational rotate-priority encoder instantiated once by the arbiter FSM.

Test Plan:
- Reset, then req=0001, data0=8'hA5 -> gnt=0001 and sel=00 one cycle later; out_data=A5 with out_valid=1 one cycle after that; drop req -> next edge gnt=0, busy=0, out_valid=0.
- req=1111 held, each owner drops req after 2 granted cycles -> grant order 0,1,2,3,0 with no cycle where gnt=0.
- Owner 2 granted, req goes from 0100 to 1001 in one cycle -> next gnt=1000 (search starts at 3), then 0001.
- With HOLD_LIMIT_EN and MAX_HOLD=4: req=0011 held -> gnt=0001 for exactly 4 cycles, then 0010 for 4, then back to 0001. With req=0001 alone -> grant never drops.
- rst_n low for one edge during a grant to requester 3 -> gnt=0, sel=00, out_valid=0. After release with req=1000, requester 3 is granted (pointer reset to 3, so search covers 0,1,2,3).
- Random req/data for 10k cycles -> gnt always one-hot or zero; sel matches gnt; out_data equals data_in of the owner from the previous cycle whenever out_valid=1.
